pwm_multi_channel: RTL and testbench
====================================

PWM_MULTI_CHANNEL -- requirements
Module: pwm_multi_channel

Interface
REQ-001 Parameter R, default 8: counter, top and duty width in bits.
REQ-002 Parameter N, default 4: number of PWM channels.
REQ-003 Parameter PW, default 16: prescaler width in bits.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 en  input  1  run enable; 0 SHALL hold the block idle.
REQ-007 mode  input  1  0 = edge-aligned, 1 = center-aligned.
REQ-008 top  input  R  period limit.
REQ-009 prescale  input  PW  a tick SHALL occur every prescale+1 clocks.
REQ-010 duty  input  N*R  channel i duty on bits [i*R +: R].
REQ-011 load  input  1  one-clock pulse that captures mode, top and duty into shadow registers.
REQ-012 pwm_out  output  N  registered PWM outputs.
REQ-013 period_tick  output  1  one-clock pulse at each period start.
REQ-014 update_done  output  1  one-clock pulse when shadow values become active.

Function
REQ-015 Prescaler p SHALL count 0..prescale and return to 0; tick = en && (p == prescale); prescale = 0 SHALL give a tick every clock.
REQ-016 The counter cnt and direction dir SHALL change only on a tick and SHALL use the active values of top and mode (top_a, mode_a).
REQ-017 Edge mode: cnt SHALL run 0,1..top_a,0; the period is top_a+1 ticks.
REQ-018 Center mode: cnt SHALL run up 0..top_a-1, then down top_a..1, then back to 0; the period is 2*top_a ticks.
REQ-019 top_a = 0 in either mode: cnt SHALL hold at 0, every tick SHALL be a period boundary, and channel i SHALL be high iff duty_a[i] > 0.
REQ-020 Edge compare: pwm_out[i] SHALL be high when cnt < duty_a[i]; duty_a[i] = 0 SHALL give always low; duty_a[i] > top_a SHALL give always high.
REQ-021 Center compare: pwm_out[i] SHALL be high on up-count when cnt < duty_a[i] and on down-count when cnt <= duty_a[i].
REQ-022 Center result: high time SHALL be 2*duty_a[i] ticks, symmetric about cnt = 0; duty_a[i] >= top_a SHALL give always high.
REQ-023 pwm_out SHALL be registered from the current cnt, dir and active values, so it lags cnt by exactly one clock.
REQ-024 Period boundary = the tick on which cnt returns to 0; period_tick SHALL be high for the single clock following that edge.
REQ-025 load SHALL copy mode, top and duty into the shadow registers and set the pending flag.
REQ-026 At a period boundary with pending set: shadow → active on the same edge as the cnt wrap; pending SHALL clear; update_done SHALL pulse coincident with period_tick.
REQ-027 A load on the same clock as a boundary edge SHALL NOT apply at that boundary; the new values SHALL apply at the next boundary.
REQ-028 Repeated loads before a boundary: the last captured values SHALL win; update_done SHALL pulse once.
REQ-029 en = 0: p, cnt and dir SHALL clear to 0/up on the next clock, pwm_out SHALL go 0 on the next clock, and period_tick SHALL stay 0.
REQ-030 A load while en = 0 SHALL become active on the next clock and SHALL pulse update_done.
REQ-031 en 0→1: counting SHALL start at p = 0, cnt = 0, dir = up, with the first period complete.
REQ-032 Counter and compare arithmetic SHALL be unsigned R-bit and SHALL never overflow past top_a.

Reset
REQ-033 Reset assertion SHALL force pwm_out, period_tick, update_done, p, cnt and pending to 0 and dir to up immediately, without a clock edge.
REQ-034 Reset SHALL set active and shadow values to duty = 0, mode = 0, top = 2^R-1.
REQ-035 After reset release, the first tick SHALL occur prescale+1 clocks after en is first sampled high.

Verification (R=8, N=4)
REQ-036 prescale=0, top=255, duty={0,192,128,64}, edge mode, load, en=1 → ch0 64, ch1 128, ch2 192 high clocks per 256; ch3 never high; period_tick every 256 clocks.
REQ-037 top=9: duty=10 → ch always high; duty=5 → 5 high of 10 clocks; duty=0 → always low.
REQ-038 prescale=3, top=9, duty=4 → period 40 clocks, 16 clocks high, period_tick spacing 40.
REQ-039 Running duty=4, top=9; load duty=7 at mid-period → output unchanged until period_tick; next period 7/10 high; update_done coincident with period_tick; load on the boundary clock → new value applies one period later.
REQ-040 Center mode, top=10, duty=4, prescale=0 → period 20 clocks, 8 high clocks centered on cnt=0; duty=10 → always high.
REQ-041 Reset pulse mid-period with clk stopped → pwm_out=0 immediately; after release, en=1 with no load → all outputs low (duty_a=0).

Source files
------------

// File: rtl/pwm_multi_channel_if.sv
// Control/status bundle for the multi-channel PWM block.
interface pwm_multi_channel_if #(
   parameter int unsigned R  = 8,
   parameter int unsigned N  = 4,
   parameter int unsigned PW = 16
);
   logic           en;
   logic           mode;
   logic [R-1:0]   top;
   logic [PW-1:0]  prescale;
   logic [N*R-1:0] duty;
   logic           load;
   logic [N-1:0]   pwm_out;
   logic           period_tick;
   logic           update_done;

   modport master (
      output en, mode, top, prescale, duty, load,
      input  pwm_out, period_tick, update_done
   );

   modport slave (
      input  en, mode, top, prescale, duty, load,
      output pwm_out, period_tick, update_done
   );
endinterface

// File: rtl/pwm_multi_channel.sv
// N-channel PWM generator with shared prescaler, edge/center-aligned counter
// and shadowed configuration that switches over only at period boundaries.
module pwm_multi_channel #(
   parameter int unsigned R  = 8,
   parameter int unsigned N  = 4,
   parameter int unsigned PW = 16
) (
   input logic                clk,
   input logic                reset,
   pwm_multi_channel_if.slave bus
);

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_t;

   logic [PW-1:0]  p;
   logic [R-1:0]   cnt;
   dir_t           dir;

   logic           mode_a;
   logic [R-1:0]   top_a;
   logic [N*R-1:0] duty_a;
   logic           mode_s;
   logic [R-1:0]   top_s;
   logic [N*R-1:0] duty_s;
   logic           pending;

   logic [N-1:0]   pwm_q;
   logic           period_tick_q;
   logic           update_done_q;

   logic           tick_c;
   logic           boundary_c;
   logic [N-1:0]   cmp_c;

   assign bus.pwm_out     = pwm_q;
   assign bus.period_tick = period_tick_q;
   assign bus.update_done = update_done_q;

   // Counter advance strobe: once every prescale+1 enabled clocks.
   assign tick_c = bus.en && (p == bus.prescale);

   // Boundary is the tick on which cnt returns to 0 (every tick when top_a is 0).
   always_comb begin
      boundary_c = 1'b0;
      if (tick_c) begin
         if (top_a == '0)
            boundary_c = 1'b1;
         else if (!mode_a)
            boundary_c = (cnt >= top_a);
         else
            boundary_c = (dir == DIR_DOWN) && (cnt <= R'(1));
      end
   end

   // Per-channel compare; the down slope uses <= so center pulses are symmetric.
   always_comb begin
      cmp_c = '0;
      for (int i = 0; i < N; i++) begin
         if (mode_a && (dir == DIR_DOWN))
            cmp_c[i] = (cnt <= duty_a[i*R +: R]);
         else
            cmp_c[i] = (cnt < duty_a[i*R +: R]);
      end
   end

   // Prescaler.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         p <= '0;
      else if (!bus.en || tick_c)
         p <= '0;
      else
         p <= p + PW'(1);
   end

   // Period counter and direction state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
         dir <= DIR_UP;
      end else if (!bus.en || boundary_c) begin
         cnt <= '0;
         dir <= DIR_UP;
      end else if (tick_c) begin
         if (!mode_a) begin
            cnt <= cnt + R'(1);
         end else if (dir == DIR_UP) begin
            cnt <= cnt + R'(1);
            if (cnt >= top_a - R'(1))
               dir <= DIR_DOWN;
         end else begin
            cnt <= cnt - R'(1);
         end
      end
   end

   // Shadow capture and shadow-to-active transfer; idle loads apply at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode_a        <= 1'b0;
         top_a         <= '1;
         duty_a        <= '0;
         mode_s        <= 1'b0;
         top_s         <= '1;
         duty_s        <= '0;
         pending       <= 1'b0;
         update_done_q <= 1'b0;
      end else begin
         update_done_q <= 1'b0;
         if (!bus.en) begin
            if (bus.load) begin
               mode_s        <= bus.mode;
               top_s         <= bus.top;
               duty_s        <= bus.duty;
               mode_a        <= bus.mode;
               top_a         <= bus.top;
               duty_a        <= bus.duty;
               pending       <= 1'b0;
               update_done_q <= 1'b1;
            end else if (pending) begin
               mode_a        <= mode_s;
               top_a         <= top_s;
               duty_a        <= duty_s;
               pending       <= 1'b0;
               update_done_q <= 1'b1;
            end
         end else begin
            if (boundary_c && pending) begin
               mode_a        <= mode_s;
               top_a         <= top_s;
               duty_a        <= duty_s;
               update_done_q <= 1'b1;
            end
            if (bus.load) begin
               mode_s  <= bus.mode;
               top_s   <= bus.top;
               duty_s  <= bus.duty;
               pending <= 1'b1;
            end else if (boundary_c) begin
               pending <= 1'b0;
            end
         end
      end
   end

   // Registered outputs: PWM lags cnt by one clock, period_tick follows the boundary edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pwm_q         <= '0;
         period_tick_q <= 1'b0;
      end else begin
         pwm_q         <= bus.en ? cmp_c : '0;
         period_tick_q <= boundary_c;
      end
   end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Self-checking bench for pwm_multi_channel: table of configurations measured
// over one full period, plus hand sequences for shadow timing, disable and reset.
module tb_pwm_multi_channel;

   localparam int unsigned R  = 8;
   localparam int unsigned N  = 4;
   localparam int unsigned PW = 16;
   localparam int unsigned LIMIT = 3000;

   logic clk     = 1'b0;
   logic reset   = 1'b1;
   bit   clk_run = 1'b1;

   int n_cmp = 0;
   int n_err = 0;

   pwm_multi_channel_if #(.R(R), .N(N), .PW(PW)) bus ();

   pwm_multi_channel #(.R(R), .N(N), .PW(PW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   // Gateable clock so reset can be exercised with no edges present.
   always begin
      #5;
      if (clk_run) clk = ~clk;
   end

   typedef struct {
      logic           mode;
      logic [R-1:0]   top;
      logic [PW-1:0]  ps;
      logic [N*R-1:0] duty;
      int             period;
      logic [N*16-1:0] high;
   } vec_t;

   vec_t vecs[7];
   vec_t sb[$];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic m, input logic [R-1:0] t, input logic [PW-1:0] ps,
                               input logic [N*R-1:0] d, input int per, input logic [N*16-1:0] h);
      vec_t v;
      v.mode = m; v.top = t; v.ps = ps; v.duty = d; v.period = per; v.high = h;
      return v;
   endfunction

   // Wait for a period_tick, then count clocks and per-channel high samples up to the next one.
   task automatic measure(output int period, output logic [N*16-1:0] highs, output bit ok);
      int waited;
      waited = 0;
      period = 0;
      highs  = '0;
      ok     = 1'b0;
      while (!bus.period_tick && waited < LIMIT) begin
         step();
         waited++;
      end
      if (!bus.period_tick) return;
      do begin
         step();
         period++;
         for (int i = 0; i < N; i++)
            if (bus.pwm_out[i]) highs[i*16 +: 16] = highs[i*16 +: 16] + 16'd1;
      end while (!bus.period_tick && period < LIMIT);
      ok = bus.period_tick;
   endtask

   // Configure while idle (applies immediately), then enable.
   task automatic configure(input logic m, input logic [R-1:0] t, input logic [PW-1:0] ps,
                            input logic [N*R-1:0] d, input string nm);
      bus.en = 1'b0;
      step();
      bus.mode = m; bus.top = t; bus.prescale = ps; bus.duty = d; bus.load = 1'b1;
      step();
      bus.load = 1'b0;
      check({nm, "_idle_load_upd"}, 64'(bus.update_done), 64'd1);
      bus.en = 1'b1;
   endtask

   initial begin
      int per;
      logic [N*16-1:0] hs;
      bit ok;
      vec_t e;
      int hi0, hi1, upd, lowc;

      bus.en = 1'b0; bus.mode = 1'b0; bus.top = '0; bus.prescale = '0;
      bus.duty = '0; bus.load = 1'b0;

      //                mode top    ps     duty {ch3,ch2,ch1,ch0}            period high {ch3,ch2,ch1,ch0}
      vecs[0] = mk(1'b0, 8'd255, 16'd0, {8'd0, 8'd192, 8'd128, 8'd64}, 256, {16'd0, 16'd192, 16'd128, 16'd64});
      vecs[1] = mk(1'b0, 8'd9,   16'd0, {8'd9, 8'd0,   8'd5,   8'd10}, 10,  {16'd9, 16'd0,   16'd5,   16'd10});
      vecs[2] = mk(1'b0, 8'd9,   16'd3, {8'd1, 8'd10,  8'd0,   8'd4},  40,  {16'd4, 16'd40,  16'd0,   16'd16});
      vecs[3] = mk(1'b1, 8'd10,  16'd0, {8'd1, 8'd0,   8'd10,  8'd4},  20,  {16'd2, 16'd0,   16'd20,  16'd8});
      vecs[4] = mk(1'b0, 8'd0,   16'd0, {8'd0, 8'd255, 8'd1,   8'd0},  1,   {16'd0, 16'd1,   16'd1,   16'd0});
      vecs[5] = mk(1'b1, 8'd1,   16'd1, {8'd1, 8'd0,   8'd0,   8'd1},  4,   {16'd4, 16'd0,   16'd0,   16'd4});
      vecs[6] = mk(1'b1, 8'd0,   16'd2, {8'd1, 8'd0,   8'd3,   8'd0},  3,   {16'd3, 16'd0,   16'd3,   16'd0});

      // Reset state.
      repeat (3) step();
      check("rst_pwm", 64'(bus.pwm_out), 64'd0);
      check("rst_period_tick", 64'(bus.period_tick), 64'd0);
      check("rst_update_done", 64'(bus.update_done), 64'd0);
      reset = 1'b0;
      step();

      // Table-driven configurations.
      for (int vi = 0; vi < 7; vi++) begin
         configure(vecs[vi].mode, vecs[vi].top, vecs[vi].ps, vecs[vi].duty, $sformatf("v%0d", vi));
         sb.push_back(vecs[vi]);
         measure(per, hs, ok);
         if (sb.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL v%0d_scoreboard: got empty queue, expected entry", vi);
         end else begin
            e = sb.pop_front();
            check($sformatf("v%0d_timeout", vi), 64'(ok), 64'd1);
            check($sformatf("v%0d_period", vi), 64'(per), 64'(e.period));
            for (int i = 0; i < N; i++)
               check($sformatf("v%0d_ch%0d_high", vi, i), 64'(hs[i*16 +: 16]), 64'(e.high[i*16 +: 16]));
         end
      end

      // Shadow timing: mid-period double load, then a load on the boundary clock.
      configure(1'b0, 8'd9, 16'd0, {8'd0, 8'd0, 8'd10, 8'd4}, "seq");
      measure(per, hs, ok);
      check("seq_base_ch0", 64'(hs[15:0]), 64'd4);
      hi0 = 0; upd = 0;
      for (int k = 1; k <= 10; k++) begin
         step();
         if (bus.pwm_out[0]) hi0++;
         if (bus.update_done) upd++;
         if (k == 4) begin bus.duty = {8'd0, 8'd0, 8'd10, 8'd3}; bus.load = 1'b1; end
         if (k == 5) bus.duty = {8'd0, 8'd0, 8'd10, 8'd7};
         if (k == 6) bus.load = 1'b0;
      end
      check("mid_load_old_ch0", 64'(hi0), 64'd4);
      check("mid_load_tick", 64'(bus.period_tick), 64'd1);
      check("mid_load_upd_coincident", 64'(bus.update_done), 64'd1);
      check("mid_load_upd_once", 64'(upd), 64'd1);

      hi0 = 0; upd = 0;
      for (int k = 1; k <= 10; k++) begin
         step();
         if (bus.pwm_out[0]) hi0++;
         if (bus.update_done) upd++;
         if (k == 9) begin bus.duty = {8'd0, 8'd0, 8'd10, 8'd2}; bus.load = 1'b1; end
      end
      bus.load = 1'b0;
      check("new_duty_ch0", 64'(hi0), 64'd7);
      check("bnd_load_tick", 64'(bus.period_tick), 64'd1);
      check("bnd_load_no_upd", 64'(upd), 64'd0);

      hi0 = 0; hi1 = 0;
      for (int k = 1; k <= 10; k++) begin
         step();
         if (bus.pwm_out[0]) hi0++;
         if (bus.pwm_out[1]) hi1++;
      end
      check("bnd_load_held_ch0", 64'(hi0), 64'd7);
      check("bnd_load_late_upd", 64'(bus.update_done), 64'd1);
      check("ch1_always_high", 64'(hi1), 64'd10);

      hi0 = 0;
      for (int k = 1; k <= 10; k++) begin
         step();
         if (bus.pwm_out[0]) hi0++;
      end
      check("bnd_load_applied_ch0", 64'(hi0), 64'd2);

      // Disable: outputs drop next clock, no period ticks while idle.
      check("pre_dis_ch1", 64'(bus.pwm_out[1]), 64'd1);
      bus.en = 1'b0;
      step();
      check("dis_pwm", 64'(bus.pwm_out), 64'd0);
      upd = 0;
      for (int k = 0; k < 12; k++) begin
         step();
         if (bus.period_tick) upd++;
      end
      check("dis_no_tick", 64'(upd), 64'd0);

      // Asynchronous reset with the clock stopped.
      configure(1'b0, 8'd9, 16'd0, {8'd0, 8'd0, 8'd255, 8'd0}, "arst");
      repeat (3) step();
      check("arst_pre_ch1", 64'(bus.pwm_out[1]), 64'd1);
      clk_run = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      check("arst_pwm_now", 64'(bus.pwm_out), 64'd0);
      #10;
      reset = 1'b0;
      #10;
      clk_run = 1'b1;
      lowc = 0;
      for (int k = 0; k < 40; k++) begin
         step();
         if (bus.pwm_out != '0) lowc++;
      end
      check("arst_default_duty_low", 64'(lowc), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Global watchdog.
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

endmodule
